hazard_ctrl_unit: RTL and testbench

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/hazard_ctrl_unit_if.sv | 34 +++
 rtl/hz_mc_counter.sv | 35 +++
 rtl/hazard_ctrl_unit.sv | 152 +++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the hazard control slice.
// FSM encoding and stall-counter constants.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MCBUSY = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } hz_state_t;

  localparam int unsigned STALL_CNT_W = 32;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle of all non-clock hazard control signals.
// The hz modport is the controller's view.
interface hazard_ctrl_unit_if #(
  parameter int STAGES = 4,
  parameter int REG_AW = 5
);
  logic              nRST;
  logic              ihit;
  logic              dhit;
  logic              memcuDRE;
  logic              memcuDWE;
  logic              exDRE;
  logic [REG_AW-1:0] exRd;
  logic [REG_AW-1:0] idRs;
  logic [REG_AW-1:0] idRt;
  logic              idUsesRs;
  logic              idUsesRt;
  logic              exBranchTaken;
  logic              idJump;
  logic              exMulti;
  logic              memHalt;
  logic              pcW;
  logic [STAGES-1:0] stageW;
  logic [STAGES-1:0] stageRST;
  logic              halt;
  logic [31:0]       stallCnt;

  modport hz (
    input  nRST, ihit, dhit, memcuDRE, memcuDWE,
    input  exDRE, exRd, idRs, idRt, idUsesRs, idUsesRt,
    input  exBranchTaken, idJump, exMulti, memHalt,
    output pcW, stageW, stageRST, halt, stallCnt
  );
endinterface

// File: rtl/hz_mc_counter.sv
// Down-counter tracking multicycle EX occupancy.
// last is high while the count sits at one.
module hz_mc_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: freezes, flushes, stalls,
// multicycle EX occupancy and halt drain sequencing.
module hazard_ctrl_unit
  import cpu_types_pkg::*;
#(
  parameter int          STAGES         = 4,
  parameter int          MC_LAT         = 4,
  parameter int          REG_AW         = 5,
  parameter logic [31:0] STALL_CNT_INIT = 32'h0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              memcuDRE,
  input  logic              memcuDWE,
  input  logic              exDRE,
  input  logic [REG_AW-1:0] exRd,
  input  logic [REG_AW-1:0] idRs,
  input  logic [REG_AW-1:0] idRt,
  input  logic              idUsesRs,
  input  logic              idUsesRt,
  input  logic              exBranchTaken,
  input  logic              idJump,
  input  logic              exMulti,
  input  logic              memHalt,
  output logic              pcW,
  output logic [STAGES-1:0] stageW,
  output logic [STAGES-1:0] stageRST,
  output logic              halt,
  output logic [31:0]       stallCnt
);

  localparam int CW = $clog2(MC_LAT) + 1;

  hz_state_t state_d, state_q;
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic freeze;
  logic load_use;
  logic mc_load;
  logic mc_dec;
  logic mc_last;

  assign freeze = (memcuDRE | memcuDWE) & ~dhit;

  // x0 is hardwired, so a load targeting it never creates a hazard
  assign load_use = exDRE && (exRd != '0) &&
                    ((idUsesRs && idRs == exRd) ||
                     (idUsesRt && idRt == exRd));

  hz_mc_counter #(.W(CW)) u_mc_counter (
    .clk      (CLK),
    .rst_n    (nRST),
    .load     (mc_load),
    .dec      (mc_dec),
    .load_val (CW'(MC_LAT - 1)),
    .last     (mc_last)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mc_load = 1'b0;
    mc_dec  = 1'b0;
    if (!freeze) begin
      unique case (state_q)
        RUN: begin
          if (memHalt) begin
            state_d = DRAIN;
          end else if (exMulti) begin
            state_d = MCBUSY;
            mc_load = 1'b1;
          end
        end
        MCBUSY: begin
          if (memHalt) begin
            state_d = DRAIN;
          end else begin
            mc_dec = 1'b1;
            if (mc_last) state_d = RUN;
          end
        end
        DRAIN:   state_d = HALTED;
        HALTED:  state_d = HALTED;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    pcW      = 1'b1;
    stageW   = '1;
    stageRST = '0;
    if (!nRST) begin
      pcW      = 1'b0;
      stageW   = '0;
      stageRST = '1;
    end else if (freeze || state_q == HALTED) begin
      pcW    = 1'b0;
      stageW = '0;
    end else if (state_q == DRAIN) begin
      pcW      = 1'b0;
      stageRST = '1;
    end else if (memHalt) begin
      // older work in MEM/WB retires while everything behind it bubbles
      pcW                   = 1'b0;
      stageRST[STAGES-2:0] = '1;
    end else if (exBranchTaken) begin
      stageRST[1:0] = 2'b11;
    end else if (state_q == MCBUSY) begin
      pcW         = 1'b0;
      stageW[1:0] = 2'b00;
      stageRST[2] = 1'b1;
    end else if (load_use) begin
      pcW         = 1'b0;
      stageW[0]   = 1'b0;
      stageRST[1] = 1'b1;
    end else if (idJump) begin
      stageRST[0] = 1'b1;
    end else if (!ihit) begin
      pcW         = 1'b0;
      stageW[0]   = 1'b0;
      stageRST[1] = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pcW && state_q != HALTED && stall_cnt_q != STALL_CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= STALL_CNT_INIT;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halt     = (state_q == HALTED);
  assign stallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: a 4-stage and a
// 6-stage instance (the latter with a preloaded stall count).
module tb_hazard_ctrl_unit;

  logic       CLK;
  logic       nRST;
  logic       ihit, dhit, memcuDRE, memcuDWE, exDRE;
  logic [4:0] exRd, idRs, idRt;
  logic       idUsesRs, idUsesRt, exBranchTaken, idJump;
  logic       exMulti, memHalt;

  logic        pcW, halt;
  logic [3:0]  stageW, stageRST;
  logic [31:0] stallCnt;

  logic        pcW6, halt6;
  logic [5:0]  stageW6, stageRST6;
  logic [31:0] stallCnt6;

  int vectors;
  int miscompares;

  hazard_ctrl_unit dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .memcuDRE(memcuDRE), .memcuDWE(memcuDWE), .exDRE(exDRE),
    .exRd(exRd), .idRs(idRs), .idRt(idRt),
    .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .exBranchTaken(exBranchTaken), .idJump(idJump),
    .exMulti(exMulti), .memHalt(memHalt),
    .pcW(pcW), .stageW(stageW), .stageRST(stageRST),
    .halt(halt), .stallCnt(stallCnt)
  );

  hazard_ctrl_unit #(
    .STAGES(6), .STALL_CNT_INIT(32'hFFFF_FFFD)
  ) dut6 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .memcuDRE(memcuDRE), .memcuDWE(memcuDWE), .exDRE(exDRE),
    .exRd(exRd), .idRs(idRs), .idRt(idRt),
    .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .exBranchTaken(exBranchTaken), .idJump(idJump),
    .exMulti(exMulti), .memHalt(memHalt),
    .pcW(pcW6), .stageW(stageW6), .stageRST(stageRST6),
    .halt(halt6), .stallCnt(stallCnt6)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b1; memcuDRE = 1'b0; memcuDWE = 1'b0;
    exDRE = 1'b0; exRd = '0; idRs = '0; idRt = '0;
    idUsesRs = 1'b0; idUsesRt = 1'b0; exBranchTaken = 1'b0;
    idJump = 1'b0; exMulti = 1'b0; memHalt = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    nRST = 1'b1;
    #2 nRST = 1'b0;
    tick();
    @(negedge CLK);
    vectors++;
    if ({pcW, stageW, stageRST} !== 9'b0_0000_1111) begin
      miscompares++;
      $display("FAIL rst_outs got %b want %b", {pcW, stageW, stageRST}, 9'b0_0000_1111);
    end
    vectors++;
    if ({halt, stallCnt} !== 33'd0) begin
      miscompares++;
      $display("FAIL rst_halt_cnt got %b/%h want 0/0", halt, stallCnt);
    end
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({pcW, stageW, stageRST} !== 9'b1_1111_0000) begin
      miscompares++;
      $display("FAIL run_default got %b want %b", {pcW, stageW, stageRST}, 9'b1_1111_0000);
    end
    tick();
  endtask

  task automatic test_load_use();
    exDRE = 1'b1; exRd = 5'd5; idRs = 5'd5; idUsesRs = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({pcW, stageW, stageRST} !== 9'b0_1110_0010) begin
      miscompares++;
      $display("FAIL lu_rs got %b want %b", {pcW, stageW, stageRST}, 9'b0_1110_0010);
    end
    tick();
    exRd = 5'd0; idRs = 5'd0;
    @(negedge CLK);
    vectors++;
    if ({pcW, stageW, stageRST} !== 9'b1_1111_0000) begin
      miscompares++;
      $display("FAIL lu_r0 got %b want %b", {pcW, stageW, stageRST}, 9'b1_1111_0000);
    end
    tick();
    exRd = 5'd7; idRs = 5'd3; idRt = 5'd7; idUsesRs = 1'b1; idUsesRt = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({pcW, stageW, stageRST} !== 9'b0_1110_0010) begin
      miscompares++;
      $display("FAIL lu_rt got %b want %b", {pcW, stageW, stageRST}, 9'b0_1110_0010);
    end
    tick();
    idUsesRt = 1'b0;
    @(negedge CLK);
    vectors++;
    if (pcW !== 1'b1 || stallCnt !== 32'd2) begin
      miscompares++;
      $display("FAIL lu_unused got pcW=%b cnt=%0d want 1/2", pcW, stallCnt);
    end
    tick();
    idle();
  endtask

  task automatic test_jump_fetch();
    idJump = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({pcW, stageW, stageRST} !== 9'b1_1111_0001) begin
      miscompares++;
      $display("FAIL jump got %b want %b", {pcW, stageW, stageRST}, 9'b1_1111_0001);
    end
    tick();
    idJump = 1'b0; ihit = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({pcW, stageW, stageRST} !== 9'b0_1110_0010) begin
      miscompares++;
      $display("FAIL fetch_miss got %b want %b", {pcW, stageW, stageRST}, 9'b0_1110_0010);
    end
    tick();
    idle();
  endtask

  task automatic test_freeze_branch();
    memcuDRE = 1'b1; dhit = 1'b0; exBranchTaken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      vectors++;
      if ({pcW, stageW} !== 5'b0_0000) begin
        miscompares++;
        $display("FAIL freeze_%0d got %b want %b", i, {pcW, stageW}, 5'b0_0000);
      end
      tick();
    end
    dhit = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({pcW, stageW, stageRST} !== 9'b1_1111_0011) begin
      miscompares++;
      $display("FAIL freeze_release got %b want %b", {pcW, stageW, stageRST}, 9'b1_1111_0011);
    end
    vectors++;
    if (stallCnt !== 32'd6) begin
      miscompares++;
      $display("FAIL freeze_cnt got %0d want 6", stallCnt);
    end
    tick();
    memcuDRE = 1'b0;
    exDRE = 1'b1; exRd = 5'd9; idRs = 5'd9; idUsesRs = 1'b1; idJump = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({pcW, stageW, stageRST} !== 9'b1_1111_0011) begin
      miscompares++;
      $display("FAIL br_over_lu got %b want %b", {pcW, stageW, stageRST}, 9'b1_1111_0011);
    end
    tick();
    idle();
  endtask

  task automatic test_multicycle();
    exMulti = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({pcW, stageW, stageRST} !== 9'b1_1111_0000) begin
      miscompares++;
      $display("FAIL mc_entry got %b want %b", {pcW, stageW, stageRST}, 9'b1_1111_0000);
    end
    tick();
    exMulti = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      vectors++;
      if ({pcW, stageW, stageRST} !== 9'b0_1100_0100) begin
        miscompares++;
        $display("FAIL mc_busy_%0d got %b want %b", i, {pcW, stageW, stageRST}, 9'b0_1100_0100);
      end
      tick();
    end
    @(negedge CLK);
    vectors++;
    if (pcW !== 1'b1 || stallCnt !== 32'd9) begin
      miscompares++;
      $display("FAIL mc_done got pcW=%b cnt=%0d want 1/9", pcW, stallCnt);
    end
    exMulti = 1'b1;
    tick();
    exMulti = 1'b0;
    tick();
    memcuDWE = 1'b1; dhit = 1'b0;
    tick();
    tick();
    idle();
    @(negedge CLK);
    vectors++;
    if ({pcW, stageW, stageRST} !== 9'b0_1100_0100) begin
      miscompares++;
      $display("FAIL mc_post_freeze got %b want %b", {pcW, stageW, stageRST}, 9'b0_1100_0100);
    end
    tick();
    tick();
    @(negedge CLK);
    vectors++;
    if (pcW !== 1'b1 || stallCnt !== 32'd14) begin
      miscompares++;
      $display("FAIL mc_ext_done got pcW=%b cnt=%0d want 1/14", pcW, stallCnt);
    end
    tick();
  endtask

  task automatic test_halt();
    memHalt = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({pcW, stageW, stageRST} !== 9'b0_1111_0111) begin
      miscompares++;
      $display("FAIL halt_entry got %b want %b", {pcW, stageW, stageRST}, 9'b0_1111_0111);
    end
    vectors++;
    if ({pcW6, stageW6, stageRST6} !== 13'b0_111111_011111) begin
      miscompares++;
      $display("FAIL halt_entry6 got %b want %b", {pcW6, stageW6, stageRST6}, 13'b0_111111_011111);
    end
    tick();
    memHalt = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({halt, pcW, stageW, stageRST} !== 10'b0_0_1111_1111) begin
      miscompares++;
      $display("FAIL drain got %b want %b", {halt, pcW, stageW, stageRST}, 10'b0_0_1111_1111);
    end
    vectors++;
    if ({pcW6, stageW6, stageRST6} !== 13'b0_111111_111111) begin
      miscompares++;
      $display("FAIL drain6 got %b want %b", {pcW6, stageW6, stageRST6}, 13'b0_111111_111111);
    end
    tick();
    ihit = 1'b0; exMulti = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      vectors++;
      if ({halt, pcW, stageW} !== 6'b1_0_0000) begin
        miscompares++;
        $display("FAIL halted_%0d got %b want %b", i, {halt, pcW, stageW}, 6'b1_0_0000);
      end
      tick();
    end
    vectors++;
    if (stallCnt !== 32'd16) begin
      miscompares++;
      $display("FAIL halted_cnt got %0d want 16", stallCnt);
    end
    idle();
    nRST = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({halt, pcW, stageW, stageRST} !== 10'b0_0_0000_1111) begin
      miscompares++;
      $display("FAIL halt_rst got %b want %b", {halt, pcW, stageW, stageRST}, 10'b0_0_0000_1111);
    end
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({halt, pcW, stageW, stageRST} !== 10'b0_1_1111_0000) begin
      miscompares++;
      $display("FAIL halt_exit got %b want %b", {halt, pcW, stageW, stageRST}, 10'b0_1_1111_0000);
    end
    tick();
  endtask

  task automatic test_reset_mid_mc();
    exMulti = 1'b1;
    tick();
    exMulti = 1'b0;
    tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      vectors++;
      if ({pcW, stageW, stageRST} !== 9'b1_1111_0000) begin
        miscompares++;
        $display("FAIL mc_abandon_%0d got %b want %b", i, {pcW, stageW, stageRST}, 9'b1_1111_0000);
      end
      tick();
    end
  endtask

  task automatic test_stages6_branch();
    exBranchTaken = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({pcW6, stageW6, stageRST6} !== 13'b1_111111_000011) begin
      miscompares++;
      $display("FAIL branch6 got %b want %b", {pcW6, stageW6, stageRST6}, 13'b1_111111_000011);
    end
    tick();
    idle();
  endtask

  task automatic test_saturate();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    ihit = 1'b0;
    tick();
    @(negedge CLK);
    vectors++;
    if (stallCnt6 !== 32'hFFFF_FFFE) begin
      miscompares++;
      $display("FAIL sat_step got %h want fffffffe", stallCnt6);
    end
    tick();
    tick();
    tick();
    idle();
    @(negedge CLK);
    vectors++;
    if (stallCnt6 !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL sat_hold got %h want ffffffff", stallCnt6);
    end
    vectors++;
    if (stallCnt !== 32'd4) begin
      miscompares++;
      $display("FAIL sat_ref got %0d want 4", stallCnt);
    end
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_load_use();
    test_jump_fetch();
    test_freeze_branch();
    test_multicycle();
    test_halt();
    test_reset_mid_mc();
    test_stages6_branch();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
